// File: rtl/lpc_lattice_synth_pkg.sv
// lpc_lattice_synth_pkg
//   Shared Q15 arithmetic constants and the lattice FSM state type used by the
//   LPC lattice synthesis filter and its shared multiply-accumulate unit.
//   No ports.
package lpc_lattice_synth_pkg;

  // Rounding bias added to the full product before dropping the 15 fraction bits.
  localparam logic signed [31:0] Q15_ROUND = 32'sh0000_4000;
  localparam int                 Q15_SHIFT = 15;
  localparam logic signed [15:0] Q15_MAX   = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN   = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STF  = 2'd1,
    STB  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/lpc_lattice_synth_if.sv
// lpc_lattice_synth_if
//   Coefficient-load and sample-stream signals of the lattice synthesis filter.
//   master: unpacker side (drives coefficients and excitation, sees output).
//   slave : filter side.
//   coef_in/coef_v/coef_clr : coefficient write / index and memory clear
//   x_in/x_v/x_rdy          : excitation sample handshake
//   y/vout                  : synthesised sample and its one-cycle valid pulse
interface lpc_lattice_synth_if #(
  parameter int W = 16
);
  logic signed [W-1:0] coef_in;
  logic                coef_v;
  logic                coef_clr;
  logic signed [W-1:0] x_in;
  logic                x_v;
  logic                x_rdy;
  logic signed [W-1:0] y;
  logic                vout;

  modport master (
    output coef_in, coef_v, coef_clr, x_in, x_v,
    input  x_rdy, y, vout
  );

  modport slave (
    input  coef_in, coef_v, coef_clr, x_in, x_v,
    output x_rdy, y, vout
  );
endinterface

// File: rtl/lpc_lattice_synth_q15_mac.sv
// lpc_lattice_synth_q15_mac
//   Combinational r = a +/- rnd(b*c), rnd(p) = (p + 0x4000) >>> 15 on the full
//   signed product. Shared by both half-steps of every lattice stage.
//   a, b, c : signed Q15 operands
//   sub     : 1 selects a - rnd(b*c), 0 selects a + rnd(b*c)
//   r       : signed Q15 result
//   Build option LPC_SYNTH_SAT_EN: result saturates to [0x8000, 0x7FFF];
//   otherwise it wraps to W bits.
module lpc_lattice_synth_q15_mac
  import lpc_lattice_synth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic                sub,
  output logic signed [W-1:0] r
);
  localparam int PW = 2 * W;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_b;
  logic signed [PW-1:0] prod_rnd;
  logic signed [PW-1:0] sum;

  always_comb begin
    prod     = PW'(b) * PW'(c);
    prod_b   = prod + PW'(Q15_ROUND);
    // prod_b is a signed variable, so this shift is arithmetic.
    prod_rnd = prod_b >>> Q15_SHIFT;
    // Summing at double width keeps the true result for the saturation check.
    sum      = sub ? (PW'(a) - prod_rnd) : (PW'(a) + prod_rnd);
`ifdef LPC_SYNTH_SAT_EN
    if (sum > PW'(Q15_MAX)) begin
      r = W'(Q15_MAX);
    end else if (sum < PW'(Q15_MIN)) begin
      r = W'(Q15_MIN);
    end else begin
      r = W'(sum);
    end
`else
    r = W'(sum);
`endif
  end
endmodule

// File: rtl/lpc_lattice_synth.sv
// lpc_lattice_synth
//   All-pole LPC lattice synthesis filter. Holds ORDER Q15 reflection
//   coefficients k[] and the backward lattice memory bst[]; each accepted
//   excitation sample walks the stages from i=ORDER-1 down to 0, two cycles per
//   stage on one shared multiplier, then emits y with a one-cycle vout pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lpc_lattice_synth_if.slave (coefficient load, sample handshake,
//              output sample)
//   Build option LPC_SYNTH_SAT_EN (in the MAC): saturating add/sub.
//
//   state | meaning
//   IDLE  | load/clear coefficients, wait for an excitation sample
//   STF   | forward update  f <= f - rnd(k[i]*bst[i])
//   STB   | backward update bst[i+1] <= bst[i] + rnd(k[i]*f), step i down
//   OUT   | publish y, seed bst[0] with the new output
module lpc_lattice_synth
  import lpc_lattice_synth_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  lpc_lattice_synth_if.slave bus
);
  localparam int             IW     = $clog2(ORDER);
  localparam logic [IW-1:0]  I_LAST = IW'(ORDER - 1);

  state_t              state, state_nxt;
  logic signed [W-1:0] k   [ORDER];
  logic signed [W-1:0] bst [ORDER];
  logic signed [W-1:0] f;
  logic signed [W-1:0] y_r;
  logic                vout_r;
  logic [IW-1:0]       i;
  logic [IW-1:0]       coef_idx;
  logic                x_rdy;
  logic                accept;
  logic signed [W-1:0] mac_a;
  logic signed [W-1:0] mac_c;
  logic signed [W-1:0] mac_r;
  logic                mac_sub;

  assign x_rdy     = (state == IDLE) && !bus.coef_v && !bus.coef_clr;
  assign accept    = bus.x_v && x_rdy;
  assign bus.x_rdy = x_rdy;
  assign bus.y     = y_r;
  assign bus.vout  = vout_r;

  lpc_lattice_synth_q15_mac #(.W(W)) u_mac (
    .a   (mac_a),
    .b   (k[i]),
    .c   (mac_c),
    .sub (mac_sub),
    .r   (mac_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mac_a     = f;
    mac_c     = bst[i];
    mac_sub   = 1'b1;
    case (state)
      IDLE: if (accept) state_nxt = STF;
      STF:  state_nxt = STB;
      STB: begin
        mac_a     = bst[i];
        mac_c     = f;
        mac_sub   = 1'b0;
        state_nxt = (i == '0) ? OUT : STF;
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f        <= '0;
      i        <= '0;
      coef_idx <= '0;
      y_r      <= '0;
      vout_r   <= 1'b0;
      for (int n = 0; n < ORDER; n++) begin
        k[n]   <= '0;
        bst[n] <= '0;
      end
    end else begin
      vout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.coef_clr) begin
            coef_idx <= '0;
            for (int n = 0; n < ORDER; n++) bst[n] <= '0;
          end else if (bus.coef_v) begin
            k[coef_idx] <= bus.coef_in;
            coef_idx    <= (coef_idx == I_LAST) ? '0 : coef_idx + IW'(1);
          end else if (accept) begin
            f <= bus.x_in;
            i <= I_LAST;
          end
        end
        STF: f <= mac_r;
        STB: begin
          // Stages run high to low, so bst[i] is still last sample's value
          // when stage i reads it; the top stage has no successor to feed.
          if (i != I_LAST) bst[i + IW'(1)] <= mac_r;
          if (i != '0) i <= i - IW'(1);
        end
        OUT: begin
          y_r    <= f;
          bst[0] <= f;
          vout_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_lattice_synth.sv
module tb_lpc_lattice_synth;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;

  lpc_lattice_synth_if #(.W(16)) bus();

  lpc_lattice_synth #(.ORDER(10), .W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Clear lattice memory, then load k[0]=c0 and k[1..9]=0.
  task automatic load_k(input logic [15:0] c0);
    @(negedge clk); bus.coef_clr = 1'b1;
    @(negedge clk); bus.coef_clr = 1'b0; bus.coef_v = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.coef_in = (j == 0) ? c0 : 16'h0000;
      @(negedge clk);
    end
    bus.coef_v = 1'b0;
  endtask

  task automatic clr_mem();
    @(negedge clk); bus.coef_clr = 1'b1;
    @(negedge clk); bus.coef_clr = 1'b0;
  endtask

  // Present one sample to an idle filter; lat counts negedges from the accepting
  // edge to the first negedge where vout is seen high.
  task automatic run_sample(input logic [15:0] x, output int lat, output logic [15:0] yv);
    @(negedge clk); bus.x_in = x; bus.x_v = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.x_v = 1'b0; lat = 1;
    while (!bus.vout && lat < 60) begin
      @(negedge clk); lat++;
    end
    yv = bus.y;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          acc_n;
    int          low_n;
    int          vout_n;
    logic [15:0] yv;
    logic [15:0] orb;
    logic [15:0] y_sat2;

`ifdef LPC_SYNTH_SAT_EN
    y_sat2 = 16'h7FFF;
`else
    y_sat2 = 16'hE000;
`endif

    bus.coef_in = '0; bus.coef_v = 1'b0; bus.coef_clr = 1'b0;
    bus.x_in = '0; bus.x_v = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_vout", 32'(bus.vout), 32'h0);
    chk("rst_xrdy", 32'(bus.x_rdy), 32'h1);
    chk("rst_cidx", 32'(dut.coef_idx), 32'h0);

    // test 1: all k=0 passes the excitation straight through
    run_sample(16'h1234, lat, yv);
    chk("t1_lat", 32'(lat), 32'd22);
    chk("t1_y", 32'(yv), 32'h1234);
    @(negedge clk);
    chk("t1_vout_pulse", 32'(bus.vout), 32'h0);
    chk("t1_y_hold", 32'(bus.y), 32'h1234);

    // test 2: k0=0.5
    load_k(16'h4000);
    run_sample(16'h4000, lat, yv);
    chk("t2_y0", 32'(yv), 32'h4000);
    run_sample(16'h0000, lat, yv);
    chk("t2_y1", 32'(yv), 32'hE000);
    run_sample(16'h0000, lat, yv);
    chk("t2_y2", 32'(yv), 32'h1000);
    chk("t2_lat", 32'(lat), 32'd22);

    // test 6: clear memory, zero input gives zero output
    clr_mem();
    run_sample(16'h0000, lat, yv);
    chk("t6_clr_y", 32'(yv), 32'h0);
    // coef_v and x_v together: coefficient wins, sample refused
    clr_mem();
    @(negedge clk);
    bus.coef_v = 1'b1; bus.coef_in = 16'h1111;
    bus.x_v = 1'b1; bus.x_in = 16'h5555;
    #1;
    chk("t6_xrdy_coef", 32'(bus.x_rdy), 32'h0);
    @(negedge clk); bus.coef_v = 1'b0; bus.x_v = 1'b0;
    chk("t6_k0", 32'(dut.k[0]), 32'h1111);
    chk("t6_cidx", 32'(dut.coef_idx), 32'h1);
    vout_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.vout) vout_n++;
    end
    chk("t6_no_accept", 32'(vout_n), 32'h0);

    // test 3: k0=-1, saturation or wrap on second sample
    load_k(16'h8000);
    run_sample(16'h7000, lat, yv);
    chk("t3_y0", 32'(yv), 32'h7000);
    run_sample(16'h7000, lat, yv);
    chk("t3_y1", 32'(yv), 32'(y_sat2));

    // test 4: x_v held high for 50 cycles
    clr_mem();
    acc_n = 0; low_n = 0;
    @(negedge clk); bus.x_v = 1'b1; bus.x_in = 16'h0100;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (bus.x_rdy) acc_n++;
      else low_n++;
      @(negedge clk);
    end
    bus.x_v = 1'b0;
    chk("t4_accepts", 32'(acc_n), 32'd3);
    chk("t4_rdy_low", 32'(low_n), 32'd47);
    lat = 0;
    while (!bus.vout && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk("t4_drain", 32'(bus.vout), 32'h1);

    // coef_v and coef_clr while busy are ignored
    load_k(16'h0123);
    @(negedge clk); bus.x_v = 1'b1; bus.x_in = 16'h0200;
    @(posedge clk);
    @(negedge clk); bus.x_v = 1'b0;
    bus.coef_v = 1'b1; bus.coef_in = 16'h7777;
    repeat (10) @(negedge clk);
    bus.coef_v = 1'b0;
    lat = 0;
    while (!bus.vout && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk("busy_vout", 32'(bus.vout), 32'h1);
    chk("busy_k0", 32'(dut.k[0]), 32'h0123);
    chk("busy_k1", 32'(dut.k[1]), 32'h0);
    chk("busy_k9", 32'(dut.k[9]), 32'h0);
    chk("busy_cidx", 32'(dut.coef_idx), 32'h0);

    // test 5: reset 10 cycles into a sample
    @(negedge clk); bus.x_v = 1'b1; bus.x_in = 16'h2000;
    @(posedge clk);
    @(negedge clk); bus.x_v = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_vout", 32'(bus.vout), 32'h0);
    chk("t5_y", 32'(bus.y), 32'h0);
    chk("t5_xrdy", 32'(bus.x_rdy), 32'h1);
    orb = '0;
    for (int n = 0; n < 10; n++) orb |= dut.bst[n];
    chk("t5_bst", 32'(orb), 32'h0);
    chk("t5_k0", 32'(dut.k[0]), 32'h0);
    vout_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.vout) vout_n++;
    end
    chk("t5_no_vout", 32'(vout_n), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
